// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM access arbiter: FSM states and the buffered
// write entry layout.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    WHOLD = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] data;
  } wr_entry_t;

  // WRITE is the only state that cannot hand the bus to a new request.
  function automatic logic is_grant_point(input arb_state_e s);
    return s != WRITE;
  endfunction

endpackage

// File: rtl/sram_wr_fifo.sv
// Small synchronous FIFO holding pending SRAM writes. The head entry is
// visible on rdata whenever the FIFO is non-empty.
module sram_wr_fifo
  import sram_arb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wr_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  entry_t                       wdata,
  output entry_t                       rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so a push while full is
  // refused even if the same cycle pops.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one asynchronous 16-bit SRAM between a display read stream and a
// buffered capture write stream; reads win unless a write has waited too long.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic                                 iCLK,
  input  logic                                 iRST,
  // Read side: iRD_REQ and iRD_ADDR are held until the cycle oRD_ACK is high;
  // the request is taken in that cycle. Write side: a push (iWR_REQ) is taken
  // in any cycle oWR_FULL is low, otherwise it is dropped and counted.
  input  logic                                 iRD_REQ,
  input  logic [ADDR_W-1:0]                    iRD_ADDR,
  output logic                                 oRD_ACK,
  output logic                                 oRD_VALID,
  output logic [DATA_W-1:0]                    oRD_DATA,
  input  logic                                 iWR_REQ,
  input  logic [ADDR_W-1:0]                    iWR_ADDR,
  input  logic [DATA_W-1:0]                    iWR_DATA,
  output logic                                 oWR_FULL,
  output logic [15:0]                          oWR_DROP_CNT,
  output logic [ADDR_W-1:0]                    oSRAM_ADDR,
  output logic [DATA_W-1:0]                    oSRAM_DQ_OUT,
  output logic                                 oSRAM_DQ_OE,
  input  logic [DATA_W-1:0]                    iSRAM_DQ,
  output logic                                 oSRAM_CE_N,
  output logic                                 oSRAM_OE_N,
  output logic                                 oSRAM_WE_N,
  output logic                                 oSRAM_UB_N,
  output logic                                 oSRAM_LB_N,
  output arb_state_e                           oDBG_STATE,
  output logic [$clog2(WR_FIFO_DEPTH+1)-1:0]   oDBG_WR_COUNT
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int         CNT_W      = $clog2(WR_FIFO_DEPTH + 1);
  localparam logic [7:0] STREAK_MAX = 8'(MAX_RD_STREAK);

  arb_state_e        state_q, state_d;
  logic [7:0]        rd_streak_q, rd_streak_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              bl_n_q, bl_n_d;

  logic              grant_pt;
  logic              wr_pref;
  logic              wr_grant;
  logic              rd_grant;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            fifo_wdata;
  entry_t            fifo_head;

  assign fifo_wdata = '{addr: iWR_ADDR, data: iWR_DATA};

  sram_wr_fifo #(
    .DEPTH   (WR_FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_wr_fifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (iWR_REQ),
    .pop   (wr_grant),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The streak cap turns a pending write into the preferred grant even while
  // reads keep arriving, bounding write latency under a busy display.
  assign grant_pt = is_grant_point(state_q);
  assign wr_pref  = !fifo_empty && (!iRD_REQ || (rd_streak_q == STREAK_MAX));
  assign wr_grant = !iRST && grant_pt && wr_pref;
  assign rd_grant = !iRST && grant_pt && !wr_pref && iRD_REQ;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WRITE: state_d = WHOLD;
      default: begin
        if (wr_grant) begin
          state_d = WRITE;
        end else if (rd_grant) begin
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Pin values are computed from the next state so every SRAM output is a
  // flop aligned with the cycle the state register reports.
  always_comb begin
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    case (state_d)
      READ: begin
        sram_addr_d = iRD_ADDR;
      end
      WRITE: begin
        sram_addr_d = fifo_head.addr;
        dq_out_d    = fifo_head.data;
      end
      default: begin
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
      end
    endcase
    dq_oe_d = (state_d == WRITE) || (state_d == WHOLD);
    ce_n_d  = (state_d == IDLE);
    oe_n_d  = (state_d != READ);
    we_n_d  = (state_d != WRITE);
    bl_n_d  = (state_d == IDLE);
  end

  always_comb begin
    rd_valid_d = (state_q == READ);
    rd_data_d  = (state_q == READ) ? iSRAM_DQ : rd_data_q;

    rd_streak_d = rd_streak_q;
    if (wr_grant || (grant_pt && !iRD_REQ)) begin
      rd_streak_d = '0;
    end else if (rd_grant && (rd_streak_q != STREAK_MAX)) begin
      rd_streak_d = rd_streak_q + 8'd1;
    end

    drop_cnt_d = drop_cnt_q;
    if (iWR_REQ && fifo_full && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= IDLE;
      rd_streak_q <= '0;
      drop_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      bl_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      rd_streak_q <= rd_streak_d;
      drop_cnt_q  <= drop_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      bl_n_q      <= bl_n_d;
    end
  end

  assign oRD_ACK       = rd_grant;
  assign oRD_VALID     = rd_valid_q;
  assign oRD_DATA      = rd_data_q;
  assign oWR_FULL      = fifo_full;
  assign oWR_DROP_CNT  = drop_cnt_q;
  assign oSRAM_ADDR    = sram_addr_q;
  assign oSRAM_DQ_OUT  = dq_out_q;
  assign oSRAM_DQ_OE   = dq_oe_q;
  assign oSRAM_CE_N    = ce_n_q;
  assign oSRAM_OE_N    = oe_n_q;
  assign oSRAM_WE_N    = we_n_q;
  assign oSRAM_UB_N    = bl_n_q;
  assign oSRAM_LB_N    = bl_n_q;
  assign oDBG_STATE    = state_q;
  assign oDBG_WR_COUNT = fifo_count;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: instance a (streak cap 8) with an
// SRAM model and read scoreboard, instance b (streak cap 255) for overflow.
module tb_sram_access_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 20;
  localparam int DW = 16;

  // ---------------- clock / reset / shared stimulus ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  always #5 clk = ~clk;

  // ---------------- instance a ----------------
  logic a_rd_ack, a_rd_valid, a_full, a_dq_oe;
  logic a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n;
  logic [DW-1:0] a_rd_data, a_dq_out;
  logic [DW-1:0] a_dq = '0;
  logic [15:0]   a_drop;
  logic [AW-1:0] a_addr;
  arb_state_e    a_state;
  logic [2:0]    a_cnt;

  sram_access_arbiter #(.MAX_RD_STREAK(8)) dut_a (
    .iCLK(clk), .iRST(rst),
    .iRD_REQ(rd_req), .iRD_ADDR(rd_addr), .oRD_ACK(a_rd_ack),
    .oRD_VALID(a_rd_valid), .oRD_DATA(a_rd_data),
    .iWR_REQ(wr_req), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
    .oWR_FULL(a_full), .oWR_DROP_CNT(a_drop),
    .oSRAM_ADDR(a_addr), .oSRAM_DQ_OUT(a_dq_out), .oSRAM_DQ_OE(a_dq_oe),
    .iSRAM_DQ(a_dq),
    .oSRAM_CE_N(a_ce_n), .oSRAM_OE_N(a_oe_n), .oSRAM_WE_N(a_we_n),
    .oSRAM_UB_N(a_ub_n), .oSRAM_LB_N(a_lb_n),
    .oDBG_STATE(a_state), .oDBG_WR_COUNT(a_cnt)
  );

  // ---------------- instance b ----------------
  logic b_rd_ack, b_rd_valid, b_full, b_dq_oe;
  logic b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;
  logic [DW-1:0] b_rd_data, b_dq_out, b_dq;
  logic [15:0]   b_drop;
  logic [AW-1:0] b_addr;
  arb_state_e    b_state;
  logic [2:0]    b_cnt;

  assign b_dq = b_addr[15:0] ^ 16'h5A5A;

  sram_access_arbiter #(.MAX_RD_STREAK(255)) dut_b (
    .iCLK(clk), .iRST(rst),
    .iRD_REQ(rd_req), .iRD_ADDR(rd_addr), .oRD_ACK(b_rd_ack),
    .oRD_VALID(b_rd_valid), .oRD_DATA(b_rd_data),
    .iWR_REQ(wr_req), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
    .oWR_FULL(b_full), .oWR_DROP_CNT(b_drop),
    .oSRAM_ADDR(b_addr), .oSRAM_DQ_OUT(b_dq_out), .oSRAM_DQ_OE(b_dq_oe),
    .iSRAM_DQ(b_dq),
    .oSRAM_CE_N(b_ce_n), .oSRAM_OE_N(b_oe_n), .oSRAM_WE_N(b_we_n),
    .oSRAM_UB_N(b_ub_n), .oSRAM_LB_N(b_lb_n),
    .oDBG_STATE(b_state), .oDBG_WR_COUNT(b_cnt)
  );

  int checks = 0;
  int fails  = 0;

  // ---------------- SRAM model for instance a ----------------
  logic [DW-1:0] mem_a [int];

  always @(negedge clk) begin
    if (!a_ce_n && !a_we_n) mem_a[int'(a_addr)] = a_dq_out;
    if (mem_a.exists(int'(a_addr))) a_dq = mem_a[int'(a_addr)];
    else a_dq = a_addr[15:0] ^ 16'h5A5A;
  end

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] addr);
    if (addr == 20'h00123) return 16'hBEEF;
    return addr[15:0] ^ 16'h5A5A;
  endfunction

  // ---------------- scoreboard for instance a reads ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sb_exp;

  always @(negedge clk) begin
    if (a_rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_valid: got oRD_VALID with data %h, required none", a_rd_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (a_rd_data !== sb_exp) begin
          fails++;
          $display("FAIL sb_rd_data: got %h, required %h", a_rd_data, sb_exp);
        end
      end
    end
    if (rst) exp_q.delete();
    else if (a_rd_ack === 1'b1) exp_q.push_back(exp_data(rd_addr));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sample();
    checks++;
    if ({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n} !== 5'b11111) begin
      fails++; $display("FAIL reset_ctrl_n: got %b, required 11111", {a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n});
    end
    checks++;
    if (a_dq_oe !== 1'b0 || a_rd_valid !== 1'b0) begin
      fails++; $display("FAIL reset_oe_valid: got dq_oe=%b valid=%b, required 0 0", a_dq_oe, a_rd_valid);
    end
    checks++;
    if (a_addr !== '0 || a_dq_out !== '0 || a_rd_data !== '0) begin
      fails++; $display("FAIL reset_data: got addr=%h dq=%h rd=%h, required 0", a_addr, a_dq_out, a_rd_data);
    end
    checks++;
    if (a_full !== 1'b0 || a_drop !== 16'd0 || a_state !== IDLE) begin
      fails++; $display("FAIL reset_status: got full=%b drop=%0d state=%0d, required 0 0 0", a_full, a_drop, a_state);
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    rd_req = 1'b1; rd_addr = 20'h00123;
    sample();
    checks++;
    if (a_rd_ack !== 1'b1) begin
      fails++; $display("FAIL read_ack: got %b, required 1", a_rd_ack);
    end
    next_cycle();
    rd_req = 1'b0;
    sample();
    checks++;
    if (a_addr !== 20'h00123 || a_oe_n !== 1'b0 || a_ce_n !== 1'b0 || a_we_n !== 1'b1 || a_dq_oe !== 1'b0) begin
      fails++; $display("FAIL read_pins: got addr=%h oe_n=%b ce_n=%b we_n=%b dq_oe=%b, required 00123 0 0 1 0",
                        a_addr, a_oe_n, a_ce_n, a_we_n, a_dq_oe);
    end
    next_cycle();
    sample();
    checks++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== 16'hBEEF) begin
      fails++; $display("FAIL read_data: got valid=%b data=%h, required 1 beef", a_rd_valid, a_rd_data);
    end
    next_cycle();
    sample();
    checks++;
    if (a_rd_valid !== 1'b0) begin
      fails++; $display("FAIL read_valid_pulse: got %b, required 0", a_rd_valid);
    end
    next_cycle();
  endtask

  task automatic test_single_write();
    wr_req = 1'b1; wr_addr = 20'h00005; wr_data = 16'h03FF;
    next_cycle();
    wr_req = 1'b0;
    sample();
    checks++;
    if (a_we_n !== 1'b1 || a_cnt !== 3'd1) begin
      fails++; $display("FAIL write_queued: got we_n=%b count=%0d, required 1 1", a_we_n, a_cnt);
    end
    next_cycle();
    sample();
    checks++;
    if (a_we_n !== 1'b0 || a_dq_oe !== 1'b1 || a_dq_out !== 16'h03FF || a_addr !== 20'h00005 || a_oe_n !== 1'b1) begin
      fails++; $display("FAIL write_pins: got we_n=%b dq_oe=%b dq=%h addr=%h oe_n=%b, required 0 1 03ff 00005 1",
                        a_we_n, a_dq_oe, a_dq_out, a_addr, a_oe_n);
    end
    next_cycle();
    sample();
    checks++;
    if (a_state !== WHOLD || a_we_n !== 1'b1 || a_dq_oe !== 1'b1 || a_addr !== 20'h00005) begin
      fails++; $display("FAIL write_hold: got state=%0d we_n=%b dq_oe=%b addr=%h, required 3 1 1 00005",
                        a_state, a_we_n, a_dq_oe, a_addr);
    end
    next_cycle();
    sample();
    checks++;
    if (a_state !== IDLE || a_ce_n !== 1'b1 || a_dq_oe !== 1'b0) begin
      fails++; $display("FAIL write_idle: got state=%0d ce_n=%b dq_oe=%b, required 0 1 0", a_state, a_ce_n, a_dq_oe);
    end
    checks++;
    if (!mem_a.exists(5) || mem_a[5] !== 16'h03FF) begin
      fails++; $display("FAIL write_mem: got %h, required 03ff", mem_a.exists(5) ? mem_a[5] : 16'hxxxx);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic          prev_ack;
    logic [AW-1:0] prev_addr;
    logic          exp_ack;
    prev_ack = 1'b0; prev_addr = '0;
    rd_req = 1'b1; rd_addr = 20'h00100;
    wr_req = 1'b1; wr_addr = 20'h00040; wr_data = 16'h1234;
    for (int c = 0; c < 14; c++) begin
      sample();
      exp_ack = (c < 8) || (c >= 10);
      checks++;
      if (a_rd_ack !== exp_ack) begin
        fails++; $display("FAIL starve_ack c=%0d: got %b, required %b", c, a_rd_ack, exp_ack);
      end
      if (prev_ack) begin
        checks++;
        if (a_addr !== prev_addr || a_oe_n !== 1'b0) begin
          fails++; $display("FAIL starve_rd_addr c=%0d: got addr=%h oe_n=%b, required %h 0", c, a_addr, a_oe_n, prev_addr);
        end
      end
      if (c == 9) begin
        checks++;
        if (a_we_n !== 1'b0 || a_addr !== 20'h00040 || a_dq_out !== 16'h1234) begin
          fails++; $display("FAIL starve_write: got we_n=%b addr=%h dq=%h, required 0 00040 1234", a_we_n, a_addr, a_dq_out);
        end
      end
      prev_ack  = a_rd_ack;
      prev_addr = rd_addr;
      next_cycle();
      wr_req = 1'b0;
      if (prev_ack) rd_addr = rd_addr + 20'd1;
    end
    rd_req = 1'b0;
    for (int c = 0; c < 3; c++) next_cycle();
    checks++;
    if (!mem_a.exists(32'h40) || mem_a[32'h40] !== 16'h1234) begin
      fails++; $display("FAIL starve_mem: got %h, required 1234", mem_a.exists(32'h40) ? mem_a[32'h40] : 16'hxxxx);
    end
  endtask

  task automatic test_overflow();
    logic [15:0]   exp_drop;
    logic          exp_oe;
    logic          exp_we_n;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_dq;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    rd_req = 1'b1; rd_addr = 20'h00200;
    for (int c = 0; c < 8; c++) begin
      wr_req  = (c < 6);
      wr_addr = AW'(32'h10 + c);
      wr_data = DW'(32'hC000 + c);
      sample();
      exp_drop = (c <= 4) ? 16'd0 : (c == 5) ? 16'd1 : 16'd2;
      checks++;
      if (b_full !== (c >= 4)) begin
        fails++; $display("FAIL ovf_full c=%0d: got %b, required %b", c, b_full, (c >= 4));
      end
      checks++;
      if (b_drop !== exp_drop) begin
        fails++; $display("FAIL ovf_drop c=%0d: got %0d, required %0d", c, b_drop, exp_drop);
      end
      checks++;
      if (b_rd_ack !== 1'b1) begin
        fails++; $display("FAIL ovf_rd_ack c=%0d: got %b, required 1", c, b_rd_ack);
      end
      next_cycle();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      sample();
      exp_oe   = (c >= 1) && (c <= 8);
      exp_we_n = !((c % 2 == 1) && (c <= 7));
      exp_addr = AW'(32'h10 + (c - 1) / 2);
      exp_dq   = DW'(32'hC000 + (c - 1) / 2);
      checks++;
      if (b_we_n !== exp_we_n || b_dq_oe !== exp_oe) begin
        fails++; $display("FAIL drain_ctrl c=%0d: got we_n=%b dq_oe=%b, required %b %b", c, b_we_n, b_dq_oe, exp_we_n, exp_oe);
      end
      if (exp_oe) begin
        checks++;
        if (b_addr !== exp_addr || b_dq_out !== exp_dq) begin
          fails++; $display("FAIL drain_entry c=%0d: got addr=%h dq=%h, required %h %h", c, b_addr, b_dq_out, exp_addr, exp_dq);
        end
      end
      if (c == 9) begin
        checks++;
        if (b_state !== IDLE || b_ce_n !== 1'b1 || b_cnt !== 3'd0 || b_full !== 1'b0) begin
          fails++; $display("FAIL drain_done: got state=%0d ce_n=%b count=%0d full=%b, required 0 1 0 0",
                            b_state, b_ce_n, b_cnt, b_full);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_stream();
    logic acked;
    checks++;
    if (a_drop !== 16'd2) begin
      fails++; $display("FAIL pre_reset_drop: got %0d, required 2", a_drop);
    end
    rd_req = 1'b1; rd_addr = 20'h00300;
    for (int c = 0; c < 3; c++) begin
      sample();
      acked = a_rd_ack;
      next_cycle();
      if (acked) rd_addr = rd_addr + 20'd1;
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; rd_req = 1'b0;
    sample();
    checks++;
    if ({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n} !== 5'b11111 || a_dq_oe !== 1'b0) begin
      fails++; $display("FAIL mid_reset_ctrl: got ctrl_n=%b dq_oe=%b, required 11111 0",
                        {a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n}, a_dq_oe);
    end
    checks++;
    if (a_rd_valid !== 1'b0 || a_full !== 1'b0 || a_drop !== 16'd0 || a_state !== IDLE) begin
      fails++; $display("FAIL mid_reset_status: got valid=%b full=%b drop=%0d state=%0d, required 0 0 0 0",
                        a_rd_valid, a_full, a_drop, a_state);
    end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      sample();
      checks++;
      if (a_rd_valid !== 1'b0) begin
        fails++; $display("FAIL mid_reset_no_valid c=%0d: got %b, required 0", c, a_rd_valid);
      end
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_write();
    wr_req = 1'b1; wr_addr = 20'h00060; wr_data = 16'hDEAD;
    next_cycle();
    wr_addr = 20'h00061; wr_data = 16'hCAFE;
    next_cycle();
    wr_req = 1'b0; rst = 1'b1;
    sample();
    checks++;
    if (a_we_n !== 1'b0 || a_addr !== 20'h00060 || a_cnt !== 3'd1) begin
      fails++; $display("FAIL rw_in_write: got we_n=%b addr=%h count=%0d, required 0 00060 1", a_we_n, a_addr, a_cnt);
    end
    next_cycle();
    rst = 1'b0;
    sample();
    checks++;
    if (a_we_n !== 1'b1 || a_dq_oe !== 1'b0 || a_ce_n !== 1'b1 || a_cnt !== 3'd0 || a_state !== IDLE) begin
      fails++; $display("FAIL rw_after_reset: got we_n=%b dq_oe=%b ce_n=%b count=%0d state=%0d, required 1 0 1 0 0",
                        a_we_n, a_dq_oe, a_ce_n, a_cnt, a_state);
    end
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      sample();
      checks++;
      if (a_we_n !== 1'b1 || a_rd_valid !== 1'b0) begin
        fails++; $display("FAIL rw_quiet c=%0d: got we_n=%b valid=%b, required 1 0", c, a_we_n, a_rd_valid);
      end
    end
    checks++;
    if (mem_a.exists(32'h61)) begin
      fails++; $display("FAIL rw_flushed: got write to 00061 data %h, required none", mem_a[32'h61]);
    end
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    mem_a[32'h123] = 16'hBEEF;
    test_reset();
    test_single_read();
    test_single_write();
    test_starvation();
    test_overflow();
    test_reset_mid_stream();
    test_reset_mid_write();
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL sb_leftover: got %0d pending reads, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
